// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, word width and sequencer state type
package alu_pkg;
  localparam int WORD_W = 64;
  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_XOR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;
endpackage

// File: rtl/alu64bit.sv
// alu64bit: combinational 64-bit ALU (NOR, XOR, ADD, SUB with carry in/out)
module alu64bit
  import alu_pkg::*;
(
  input  logic [1:0]        op,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] s,
  output logic              cout
);
  logic [WORD_W:0] sum;
  // SUB is a + ~b + cin, so cin=1 means "no borrow"; logic ops report cout=0
  always_comb begin
    sum  = {1'b0, a} + {1'b0, op == OP_SUB ? ~b : b} + {{WORD_W{1'b0}}, cin};
    s    = op == OP_NOR ? ~(a | b) : op == OP_XOR ? a ^ b : sum[WORD_W-1:0];
    cout = op[1] & sum[WORD_W];
  end
endmodule

// File: rtl/alu_wide_seq.sv
// alu_wide_seq: sequences WORDS x 64-bit operations through an external alu64bit, LSW first
module alu_wide_seq
  import alu_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WORDS*WORD_W-1:0] req_a,
  input  logic [WORDS*WORD_W-1:0] req_b,
  input  logic [1:0]              req_op,
  input  logic                    req_cin,
  output logic [WORD_W-1:0]       alu_a,
  output logic [WORD_W-1:0]       alu_b,
  output logic [1:0]              alu_op,
  output logic                    alu_cin,
  input  logic [WORD_W-1:0]       alu_s,
  input  logic                    alu_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WORDS*WORD_W-1:0] rsp_s,
  output logic                    rsp_cout
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  seq_state_t                   state_q;
  logic [IW-1:0]                idx_q;
  logic                         carry_q;
  logic                         cout_q;
  logic [1:0]                   op_q;
  logic [WORDS-1:0][WORD_W-1:0] a_q, b_q, res_q;
  logic                         run;
  assign run       = state_q == RUN;
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == DONE;
  assign rsp_s     = res_q;
  assign rsp_cout  = cout_q;
  assign alu_a     = run ? a_q[idx_q] : '0;
  assign alu_b     = run ? b_q[idx_q] : '0;
  assign alu_op    = run ? op_q : 2'b00;
  assign alu_cin   = run & carry_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          a_q     <= req_a;
          b_q     <= req_b;
          op_q    <= req_op;
          carry_q <= req_cin;
          res_q   <= '0;
          idx_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          res_q[idx_q] <= alu_s;
          carry_q      <= alu_cout;
          idx_q        <= idx_q + IW'(1);
          if (idx_q == IW'(WORDS - 1)) begin
            cout_q  <= alu_cout;
            state_q <= DONE;
          end
        end
        DONE: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_wide_seq.sv
// tb_alu_wide_seq: scoreboard bench for alu_wide_seq wired to alu64bit, WORDS=2
module tb_alu_wide_seq;
  import alu_pkg::*;
  localparam int WORDS = 2;
  localparam int N = WORDS * WORD_W;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_cin = 1'b0, rsp_valid, rsp_ready = 1'b1, rsp_cout;
  logic [N-1:0] req_a = '0, req_b = '0, rsp_s;
  logic [1:0] req_op = 2'b00, alu_op;
  logic [WORD_W-1:0] alu_a, alu_b, alu_s;
  logic alu_cin, alu_cout;
  logic [N:0] sb[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, acc_cyc = 0, last_hs = 0;

  alu_wide_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_cin(req_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
    .alu_s(alu_s), .alu_cout(alu_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout)
  );
  alu64bit u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .cin(alu_cin), .s(alu_s), .cout(alu_cout));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the whole operation as one N-bit arithmetic/logic step
  function automatic logic [N:0] model(input logic [N-1:0] a, b, input logic [1:0] op, input logic cin);
    case (op)
      OP_ADD:  model = {1'b0, a} + {1'b0, b} + (N+1)'(cin);
      OP_SUB:  model = {1'b0, a} + {1'b0, ~b} + (N+1)'(cin);
      OP_XOR:  model = {1'b0, a ^ b};
      default: model = {1'b0, ~(a | b)};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [N:0] act, input logic [N:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [N-1:0] a, b, input logic [1:0] op, input logic cin);
    int n = 0;
    req_a = a; req_b = b; req_op = op; req_cin = cin; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", 0, 1);
    sb.push_back(model(a, b, op, cin));
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_a = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) chk("rsp_timeout", 0, 1);
  endtask

  always @(negedge clk)
    if (rst_n && rsp_valid && rsp_ready) begin
      last_hs = cyc + 1;
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_rsp: got %h with no expected entry", rsp_s);
      end else chk("rsp", {rsp_cout, rsp_s}, sb.pop_front());
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;
    logic [N:0] e;
    int n;
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp", {rsp_cout, rsp_s}, 0);
    chk("rst_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    send({64'h0, {64{1'b1}}}, 128'd1, OP_ADD, 1'b0);
    wait_valid();
    chk("latency", cyc - acc_cyc, WORDS);
    @(posedge clk); #1;

    send('1, 128'd1, OP_ADD, 1'b0);
    @(posedge clk); #1;
    chk("word1_cin", alu_cin, 1);
    wait_valid();
    @(posedge clk); #1;

    send({32{4'hA}}, '1, OP_XOR, 1'b1);
    wait_valid();
    @(posedge clk); #1;

    rsp_ready = 1'b0;
    ra = {$urandom, $urandom, $urandom, $urandom};
    rb = {$urandom, $urandom, $urandom, $urandom};
    e = model(ra, rb, OP_SUB, 1'b1);
    send(ra, rb, OP_SUB, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rsp", {rsp_cout, rsp_s}, e);
      chk("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_ready", req_ready, 1);
    chk("bp_release_valid", rsp_valid, 0);

    @(posedge clk); #1;
    send('1, '1, OP_ADD, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("abort_valid", rsp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_alu", {alu_a, alu_b, alu_op, alu_cin}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'h1, OP_SUB, 1'b0);

    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, OP_ADD, 1'b0);
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, OP_NOR, 1'b1);
    chk("b2b_gap", acc_cyc, last_hs + 1);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom % 4 == 0) ? '1 : {$urandom, $urandom, $urandom, $urandom};
      rb = ($urandom % 4 == 0) ? N'(1) : {$urandom, $urandom, $urandom, $urandom};
      send(ra, rb, 2'($urandom % 4), 1'($urandom));
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("drain", (N+1)'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
